// File: rtl/wash_sequencer_pkg.sv
// rtl/wash_sequencer_pkg.sv - phase and mode codes shared by the sequencer, display and controller side
package wash_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5,
        PH_DONE  = 3'd6
    } phase_e;

    typedef enum logic [1:0] {
        MODE_FULL       = 2'd0,
        MODE_WASH_ONLY  = 2'd1,
        MODE_RINSE_SPIN = 2'd2,
        MODE_SPIN_ONLY  = 2'd3
    } mode_e;

    localparam int RINSE_CNT_W = 2;

endpackage

// File: rtl/wash_sequencer_if.sv
// rtl/wash_sequencer_if.sv - controller/status bundle between STController and the wash sequencer
interface wash_sequencer_if #(
    parameter int TIME_W = 4
);
    logic              tickSec;
    logic              run;
    logic              pause;
    logic              abort;
    logic [1:0]        mode;
    logic [2:0]        phase;
    logic [TIME_W-1:0] remain;
    logic              waterValve;
    logic              drainValve;
    logic              motorOn;
    logic              motorFast;
    logic              hadFinish;

    // Controller side: drives run/pause/abort/mode and watches status
    modport master (
        output tickSec, run, pause, abort, mode,
        input  phase, remain, waterValve, drainValve, motorOn, motorFast, hadFinish
    );

    // Sequencer side
    modport slave (
        input  tickSec, run, pause, abort, mode,
        output phase, remain, waterValve, drainValve, motorOn, motorFast, hadFinish
    );
endinterface

// File: rtl/wash_sequencer_phase_timer.sv
// rtl/wash_sequencer_phase_timer.sv - loadable per-phase down-counter with expire strobe
module wash_sequencer_phase_timer #(
    parameter int TIME_W = 4
) (
    input  logic              cp,
    input  logic              resetBtn,
    input  logic              load_i,
    input  logic [TIME_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic [TIME_W-1:0] remain_o,
    output logic              expire_o
);
    logic [TIME_W-1:0] remain_q;
    logic [TIME_W-1:0] remain_d;

    // Load wins over decrement; never wrap below zero in IDLE/DONE
    always_comb begin
        remain_d = remain_q;
        if (load_i) begin
            remain_d = load_val_i;
        end else if (dec_i && (remain_q != '0)) begin
            remain_d = remain_q - TIME_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge cp or negedge resetBtn) begin
        if (!resetBtn) begin
            remain_q <= '0;
        end else begin
            remain_q <= remain_d;
        end
    end

    assign remain_o = remain_q;
    assign expire_o = dec_i && (remain_q == TIME_W'(1));

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - wash program sequencer: phase FSM, phase timer and registered actuators
module wash_sequencer
    import wash_sequencer_pkg::*;
#(
    parameter int TIME_W    = 4,
    parameter int FILL_T    = 2,
    parameter int WASH_T    = 4,
    parameter int DRAIN_T   = 2,
    parameter int RINSE_T   = 3,
    parameter int SPIN_T    = 3,
    parameter int RINSE_CNT = 1
) (
    input  logic          cp,
    input  logic          resetBtn,
    wash_sequencer_if.slave bus
);
    logic              active;
    logic              tick;
    logic              expire;
    logic              load;
    logic [TIME_W-1:0] load_val;
    logic [TIME_W-1:0] remain;

    phase_e                 phase_q, phase_d;
    mode_e                  mode_q, mode_d;
    logic [RINSE_CNT_W-1:0] rinse_q, rinse_d;
    logic                   abort_q, abort_d;
    logic                   washed_q, washed_d;

    logic water_q, water_d;
    logic drain_q, drain_d;
    logic motor_q, motor_d;
    logic fast_q, fast_d;

    function automatic logic [TIME_W-1:0] dur_of(input phase_e p);
        case (p)
            PH_FILL:  return TIME_W'(FILL_T);
            PH_WASH:  return TIME_W'(WASH_T);
            PH_DRAIN: return TIME_W'(DRAIN_T);
            PH_RINSE: return TIME_W'(RINSE_T);
            PH_SPIN:  return TIME_W'(SPIN_T);
            default:  return '0;
        endcase
    endfunction

    assign active = bus.run && !bus.pause;
    assign tick   = bus.tickSec && active;

    wash_sequencer_phase_timer #(
        .TIME_W (TIME_W)
    ) u_timer (
        .cp         (cp),
        .resetBtn   (resetBtn),
        .load_i     (load),
        .load_val_i (load_val),
        .dec_i      (tick),
        .remain_o   (remain),
        .expire_o   (expire)
    );

    // State register: phase, program context and registered actuators
    always_ff @(posedge cp or negedge resetBtn) begin
        if (!resetBtn) begin
            phase_q  <= PH_IDLE;
            mode_q   <= MODE_FULL;
            rinse_q  <= '0;
            abort_q  <= 1'b0;
            washed_q <= 1'b0;
            water_q  <= 1'b0;
            drain_q  <= 1'b0;
            motor_q  <= 1'b0;
            fast_q   <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            rinse_q  <= rinse_d;
            abort_q  <= abort_d;
            washed_q <= washed_d;
            water_q  <= water_d;
            drain_q  <= drain_d;
            motor_q  <= motor_d;
            fast_q   <= fast_d;
        end
    end

    // Next-state: abort is tested before the phase-end strobe so it wins
    always_comb begin
        phase_d  = phase_q;
        mode_d   = mode_q;
        rinse_d  = rinse_q;
        abort_d  = abort_q;
        washed_d = washed_q;
        case (phase_q)
            PH_IDLE: begin
                if (active) begin
                    mode_d   = mode_e'(bus.mode);
                    abort_d  = 1'b0;
                    washed_d = 1'b0;
                    case (mode_e'(bus.mode))
                        MODE_FULL:       rinse_d = RINSE_CNT_W'(RINSE_CNT);
                        MODE_RINSE_SPIN: rinse_d = RINSE_CNT_W'(1);
                        default:         rinse_d = '0;
                    endcase
                    phase_d = (mode_e'(bus.mode) == MODE_SPIN_ONLY) ? PH_SPIN : PH_FILL;
                end
            end
            PH_FILL: begin
                if (bus.abort) begin
                    phase_d = PH_DRAIN;
                    abort_d = 1'b1;
                end else if (expire) begin
                    // Only full and wash-only programs wash, and only once
                    if (((mode_q == MODE_FULL) || (mode_q == MODE_WASH_ONLY)) && !washed_q) begin
                        phase_d = PH_WASH;
                    end else begin
                        phase_d = PH_RINSE;
                    end
                end
            end
            PH_WASH: begin
                if (bus.abort) begin
                    phase_d = PH_DRAIN;
                    abort_d = 1'b1;
                end else if (expire) begin
                    phase_d  = PH_DRAIN;
                    washed_d = 1'b1;
                end
            end
            PH_RINSE: begin
                if (bus.abort) begin
                    phase_d = PH_DRAIN;
                    abort_d = 1'b1;
                end else if (expire) begin
                    phase_d = PH_DRAIN;
                    rinse_d = rinse_q - RINSE_CNT_W'(1);
                end
            end
            PH_DRAIN: begin
                if (bus.abort) begin
                    phase_d = PH_IDLE;
                end else if (expire) begin
                    if (abort_q) begin
                        phase_d = PH_IDLE;
                    end else if (mode_q == MODE_WASH_ONLY) begin
                        phase_d = PH_DONE;
                    end else if (rinse_q != '0) begin
                        phase_d = PH_FILL;
                    end else begin
                        phase_d = PH_SPIN;
                    end
                end
            end
            PH_SPIN: begin
                if (bus.abort) begin
                    phase_d = PH_IDLE;
                end else if (expire) begin
                    phase_d = PH_DONE;
                end
            end
            PH_DONE: begin
                if (!bus.run) begin
                    phase_d = PH_IDLE;
                end
            end
            default: phase_d = PH_IDLE;
        endcase
        // Every transition reloads the timer with the new phase's duration
        load     = (phase_d != phase_q);
        load_val = dur_of(phase_d);
    end

    // Output decode: actuators follow the next phase, gated while paused or stopped
    always_comb begin
        water_d = active && (phase_d == PH_FILL);
        drain_d = active && ((phase_d == PH_DRAIN) || (phase_d == PH_SPIN));
        motor_d = active && ((phase_d == PH_WASH) || (phase_d == PH_RINSE) || (phase_d == PH_SPIN));
        fast_d  = active && (phase_d == PH_SPIN);
    end

    assign bus.phase      = phase_q;
    assign bus.remain     = remain;
    assign bus.hadFinish  = (phase_q == PH_DONE);
    assign bus.waterValve = water_q;
    assign bus.drainValve = drain_q;
    assign bus.motorOn    = motor_q;
    assign bus.motorFast  = fast_q;

endmodule
